dbf_fine_apod: RTL and testbench
================================

# dbf_fine_apod

Per-channel fine-delay and apodization stage of the digital beamformer. Consumes the coarse-delayed sample stream of one channel, applies a per-sample fractional delay by linear interpolation between consecutive samples using a dynamic-focus fraction LUT, and multiplies by the apodization window value. Produces the 32-bit weighted channel output that feeds the beamformer summation tree.

## Interface
- INPUT_WD, 14, signed sample width from coarse delay
- APO_WD, 16, signed apodization coefficient width (Q1.15)
- FRAC_WD, 3, fractional delay width; fraction = value/2^FRAC_WD
- ADDR_WD, 10, fraction LUT address width; depth 2^ADDR_WD
- OUT_WD, 32, output width; must equal INPUT_WD+2+APO_WD
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-high reset: 1 = reset (name kept for codebase consistency)
- tx_en  in  1  transmit active; input samples ignored while 1
- start  in  1  receive line active; level-sensitive
- fine_din  in  INPUT_WD  signed coarse-delayed sample
- fine_din_valid  in  1  fine_din qualifier
- lut_addr  in  ADDR_WD  fraction LUT write address
- lut_we  in  1  fraction LUT write enable
- lut_din  in  FRAC_WD  fraction LUT write data
- apo_din  in  APO_WD  signed apodization value, sampled in stage B
- dout  out  OUT_WD  signed apodized, fine-delayed sample
- dout_valid  out  1  dout qualifier

## Operation
- Accepted sample: fine_din_valid & ~tx_en & state != IDLE.
- LUT: 2^ADDR_WD x FRAC_WD register array, not reset. Write on lut_we while start=0; writes while start=1 are dropped.
- FSM states:
  - IDLE: entered from reset or when start=0. Outputs forced 0, pipeline valids cleared, rd_ptr=0. Moves to PRIME when start=1.
  - PRIME: first accepted sample is loaded into x_prev; no output. Moves to RUN. If that sample arrives in the same cycle start rises, it is the prime sample.
  - RUN: each accepted sample flows through the pipeline below. Returns to IDLE when start=0.
- rd_ptr increments on every accepted sample in RUN and wraps from 2^ADDR_WD-1 to 0.
- Stage A, registered on acceptance: x_cur=fine_din, x_prev = previous x_cur, frac=lut[rd_ptr].
- Stage B: interp = (x_cur <<< FRAC_WD) + frac*(x_prev - x_cur). Signed, INPUT_WD+FRAC_WD+2 bits (19), never overflows.
- Stage C: prod = interp*apo_din, 35 bits signed. dout = prod >>> FRAC_WD, i.e. bits [34:3]. Exact fit, no saturation, truncation toward -inf.
- frac=0 yields x_cur*apo_din exactly.
- tx_en=1 in RUN: samples ignored, rd_ptr and x_prev hold. In-flight results still emerge.

## Timing
- Reset (rst_n=1 at an edge): dout=0, dout_valid=0, state IDLE, rd_ptr=0, x_prev=0, all pipeline valids 0. Takes priority over all other inputs.
- Latency: sample accepted at edge N produces dout/dout_valid registered at edge N+3. Throughput is 1 sample/cycle.
- dout_valid is high exactly one cycle per accepted RUN sample. Between samples: dout holds its last value and dout_valid=0.
- start falling at edge N: state is IDLE after edge N. Pipeline valids are flushed, so no dout_valid after edge N. dout=0 from edge N.
- Reset or start=0 mid-line discards in-flight samples. The next start re-primes with rd_ptr=0.

## Test plan
- Reset: drive random inputs with rst_n=1 for 5 cycles -> dout=0 and dout_valid=0 throughout; after release with start=0, still 0.
- Basic interpolation: LUT[0]=4, apo=16384. Stream 100 (prime), then 200 -> single dout=2457600 three cycles after the 200 edge.
- Extremes: x_prev=-8192, x_cur=8191, frac=7, apo=-32768 -> dout=201330688. Also frac=0, x=-5, apo=32767 -> dout=-163835.
- Pointer wrap with ADDR_WD=2: LUT={0,1,2,3}, stream 6 RUN samples -> fractions used 0,1,2,3,0,1.
- tx_en gating and LUT protection: toggle tx_en mid-stream -> skipped samples produce no outputs and do not advance rd_ptr. lut_we during start=1 -> LUT unchanged.
- start drop mid-pipeline: deassert start 1 cycle after acceptance -> no dout_valid. Restart -> first sample primes with no output, and frac is read from LUT[0].

Source files
------------

// File: rtl/dbf_fine_apod.sv
// dbf_fine_apod: per-channel fine delay (linear interpolation between
// consecutive samples, fraction from a dynamic-focus LUT) followed by
// apodization weighting. Output feeds the beamformer summation tree.
//
// Handshake: fine_din is taken on a rising clk edge when fine_din_valid=1,
// tx_en=0 and start=1; there is no backpressure. dout is meaningful only in
// the cycle dout_valid=1, which pulses once per sample accepted in RUN,
// three edges after that sample was taken.
module dbf_fine_apod #(
    parameter int INPUT_WD = 14,
    parameter int APO_WD   = 16,
    parameter int FRAC_WD  = 3,
    parameter int ADDR_WD  = 10,
    parameter int OUT_WD   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tx_en,
    input  logic                       start,
    input  logic signed [INPUT_WD-1:0] fine_din,
    input  logic                       fine_din_valid,
    input  logic        [ADDR_WD-1:0]  lut_addr,
    input  logic                       lut_we,
    input  logic        [FRAC_WD-1:0]  lut_din,
    input  logic signed [APO_WD-1:0]   apo_din,
    output logic signed [OUT_WD-1:0]   dout,
    output logic                       dout_valid,
    output logic        [1:0]          dbg_state
);

    localparam int INTERP_WD = INPUT_WD + FRAC_WD + 2;
    localparam int PROD_WD   = INTERP_WD + APO_WD;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic        [FRAC_WD-1:0]   r_lut [0:(1<<ADDR_WD)-1];
    logic        [ADDR_WD-1:0]   r_rd_ptr;
    logic signed [INPUT_WD-1:0]  r_x_cur;
    logic signed [INPUT_WD-1:0]  r_x_prev;
    logic        [FRAC_WD-1:0]   r_frac;
    logic                        r_va;
    logic signed [INTERP_WD-1:0] r_interp;
    logic signed [APO_WD-1:0]    r_apo;
    logic                        r_vb;
    logic signed [PROD_WD-1:0]   r_prod;
    logic                        r_vc;
    logic signed [OUT_WD-1:0]    r_dout;
    logic                        r_dout_valid;

    logic                        w_accept;
    logic                        w_prime_load;
    logic                        w_run_acc;
    logic signed [INTERP_WD-1:0] w_cur_ext;
    logic signed [INTERP_WD-1:0] w_prev_ext;
    logic signed [INTERP_WD-1:0] w_frac_ext;
    logic signed [INTERP_WD-1:0] w_interp;
    logic signed [PROD_WD-1:0]   w_prod;

    // The sample that arrives while leaving IDLE is already the prime sample,
    // so acceptance only needs start=1 rather than a non-IDLE registered state.
    assign w_accept     = fine_din_valid & ~tx_en & start;
    assign w_prime_load = w_accept & (r_state != RUN);
    assign w_run_acc    = w_accept & (r_state == RUN);

    // Interpolation: x_cur*2^F + frac*(x_prev - x_cur), all in INTERP_WD bits.
    assign w_cur_ext  = {{(INTERP_WD-INPUT_WD){r_x_cur[INPUT_WD-1]}}, r_x_cur};
    assign w_prev_ext = {{(INTERP_WD-INPUT_WD){r_x_prev[INPUT_WD-1]}}, r_x_prev};
    assign w_frac_ext = {{(INTERP_WD-FRAC_WD){1'b0}}, r_frac};
    assign w_interp   = (w_cur_ext <<< FRAC_WD) + w_frac_ext * (w_prev_ext - w_cur_ext);
    assign w_prod     = PROD_WD'(r_interp) * PROD_WD'(r_apo);

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: start=0 always returns to IDLE; one prime sample precedes RUN
    always_comb begin
        w_next_state = r_state;
        if (!start) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next_state = w_prime_load ? RUN : PRIME;
                PRIME:   w_next_state = w_prime_load ? RUN : PRIME;
                RUN:     w_next_state = RUN;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Fraction LUT: not reset; frozen while a receive line is active
    always_ff @(posedge clk) begin
        if (lut_we && !start) begin
            r_lut[lut_addr] <= lut_din;
        end
    end

    // Stage A: capture sample pair, fraction and advance the read pointer
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_x_cur  <= '0;
            r_x_prev <= '0;
            r_frac   <= '0;
            r_rd_ptr <= '0;
            r_va     <= 1'b0;
        end else if (!start) begin
            r_rd_ptr <= '0;
            r_va     <= 1'b0;
        end else begin
            r_va <= w_run_acc;
            if (w_prime_load) begin
                r_x_cur  <= fine_din;
                r_x_prev <= fine_din;
            end else if (w_run_acc) begin
                r_x_prev <= r_x_cur;
                r_x_cur  <= fine_din;
                r_frac   <= r_lut[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + ADDR_WD'(1);
            end
        end
    end

    // Stages B and C and output: interpolate, weight, then rescale by 2^-F
    always_ff @(posedge clk) begin
        if (rst_n || !start) begin
            r_vb         <= 1'b0;
            r_vc         <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
            if (rst_n) begin
                r_interp <= '0;
                r_apo    <= '0;
                r_prod   <= '0;
            end
        end else begin
            r_vb         <= r_va;
            r_vc         <= r_vb;
            r_dout_valid <= r_vc;
            if (r_va) begin
                r_interp <= w_interp;
                r_apo    <= apo_din;
            end
            if (r_vb) begin
                r_prod <= w_prod;
            end
            if (r_vc) begin
                r_dout <= r_prod[PROD_WD-1:FRAC_WD];
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_dbf_fine_apod.sv
// Directed bench for dbf_fine_apod (instantiated with a 4-entry LUT so that
// pointer wrap is reachable).
module tb_dbf_fine_apod;

    logic               clk;
    logic               rst_n;
    logic               tx_en;
    logic               start;
    logic signed [13:0] fine_din;
    logic               fine_din_valid;
    logic        [1:0]  lut_addr;
    logic               lut_we;
    logic        [2:0]  lut_din;
    logic signed [15:0] apo_din;
    logic signed [31:0] dout;
    logic               dout_valid;
    logic        [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic signed [31:0] got_q[$];
    int                 got_cyc_q[$];
    logic signed [31:0] exp_q[$];

    dbf_fine_apod #(
        .INPUT_WD(14), .APO_WD(16), .FRAC_WD(3), .ADDR_WD(2), .OUT_WD(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .start(start),
        .fine_din(fine_din), .fine_din_valid(fine_din_valid),
        .lut_addr(lut_addr), .lut_we(lut_we), .lut_din(lut_din),
        .apo_din(apo_din), .dout(dout), .dout_valid(dout_valid),
        .dbg_state(dbg_state)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // output capture
    always @(posedge clk) begin
        #1;
        if (dout_valid === 1'b1) begin
            got_q.push_back(dout);
            got_cyc_q.push_back(cyc);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic lut_write(input logic [1:0] a, input logic [2:0] d);
        lut_addr = a;
        lut_din  = d;
        lut_we   = 1'b1;
        tick();
        lut_we   = 1'b0;
    endtask

    task automatic send(input logic signed [13:0] x);
        fine_din       = x;
        fine_din_valid = 1'b1;
        tick();
        fine_din_valid = 1'b0;
    endtask

    task automatic end_line();
        start = 1'b0;
        tick();
    endtask

    task automatic clear_capture();
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            rst_n          = 1'b1;
            start          = 1'($urandom_range(0, 1));
            tx_en          = 1'($urandom_range(0, 1));
            fine_din       = 14'($urandom_range(0, 16383));
            fine_din_valid = 1'($urandom_range(0, 1));
            apo_din        = 16'($urandom_range(0, 65535));
            tick();
            checks++;
            if (dout !== 32'sd0 || dout_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d dout %0d valid %b expected 0 0", i, dout, dout_valid);
            end
        end
        rst_n = 1'b0;
        start = 1'b0;
        tx_en = 1'b0;
        fine_din_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dout !== 32'sd0 || dout_valid !== 1'b0 || dbg_state !== 2'd0) begin
                errors++;
                $display("FAIL reset_release dout %0d valid %b state %0d expected 0 0 0", dout, dout_valid, dbg_state);
            end
        end
    endtask

    task automatic test_basic();
        lut_write(2'd0, 3'd4);
        apo_din = 16'sd16384;
        clear_capture();
        // prime sample arrives in the same cycle start rises
        start = 1'b1;
        fine_din = 14'sd100;
        fine_din_valid = 1'b1;
        tick();
        checks++;
        if (dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL basic_state_run got %0d expected 2", dbg_state);
        end
        fine_din = 14'sd200;
        tick();
        fine_din_valid = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (dout_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_early_valid at N+%0d got %b expected 0", k, dout_valid);
            end
        end
        tick();
        checks++;
        if (dout_valid !== 1'b1 || dout !== 32'sd2457600) begin
            errors++;
            $display("FAIL basic_dout valid %b dout %0d expected 1 2457600", dout_valid, dout);
        end
        tick();
        checks++;
        if (dout_valid !== 1'b0 || dout !== 32'sd2457600) begin
            errors++;
            $display("FAIL basic_hold valid %b dout %0d expected 0 2457600", dout_valid, dout);
        end
        end_line();
        checks++;
        if (dout !== 32'sd0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL basic_idle dout %0d state %0d expected 0 0", dout, dbg_state);
        end
    endtask

    task automatic test_extremes();
        lut_write(2'd0, 3'd7);
        apo_din = -16'sd32768;
        clear_capture();
        start = 1'b1;
        tick();
        send(-14'sd8192);
        send(14'sd8191);
        wait_cycles(4);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 32'sd201330688) begin
            errors++;
            $display("FAIL extreme_max count %0d first %0d expected 1 201330688",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'sd0);
        end
        end_line();

        lut_write(2'd0, 3'd0);
        apo_din = 16'sd32767;
        clear_capture();
        start = 1'b1;
        send(14'sd3);
        send(-14'sd5);
        wait_cycles(4);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== -32'sd163835) begin
            errors++;
            $display("FAIL extreme_frac0 count %0d first %0d expected 1 -163835",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'sd0);
        end
        end_line();
    endtask

    task automatic test_back_to_back_wrap();
        logic signed [31:0] exp_v[6];
        logic signed [31:0] g;
        logic signed [31:0] e;
        // prev-cur = -8 each step, apo=8 -> dout = 8*cur - 8*frac, frac 0,1,2,3,0,1
        exp_v = '{32'sd64, 32'sd120, 32'sd176, 32'sd232, 32'sd320, 32'sd376};
        for (int a = 0; a < 4; a++) lut_write(2'(a), 3'(a));
        apo_din = 16'sd8;
        clear_capture();
        for (int i = 0; i < 6; i++) exp_q.push_back(exp_v[i]);
        start = 1'b1;
        send(14'sd0);
        for (int i = 1; i <= 6; i++) send(14'(8 * i));
        wait_cycles(4);
        checks++;
        if (got_q.size() != 6) begin
            errors++;
            $display("FAIL wrap_count got %0d expected 6", got_q.size());
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            g = got_q[i];
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL wrap_dout[%0d] got %0d expected %0d", i, g, e);
            end
        end
        if (got_cyc_q.size() == 6) begin
            checks++;
            if (got_cyc_q[5] - got_cyc_q[0] != 5) begin
                errors++;
                $display("FAIL wrap_throughput span %0d expected 5", got_cyc_q[5] - got_cyc_q[0]);
            end
        end
        end_line();
    endtask

    task automatic test_tx_gating();
        logic signed [31:0] g;
        logic signed [31:0] e;
        for (int a = 0; a < 4; a++) lut_write(2'(a), 3'(a));
        apo_din = 16'sd8;
        clear_capture();
        exp_q.push_back(32'sd64);
        exp_q.push_back(32'sd120);
        exp_q.push_back(32'sd176);
        start = 1'b1;
        send(14'sd0);
        send(14'sd8);
        tx_en = 1'b1;
        fine_din = 14'sd999;
        fine_din_valid = 1'b1;
        wait_cycles(2);
        fine_din_valid = 1'b0;
        tx_en = 1'b0;
        // write attempt while line active must be dropped
        lut_write(2'd0, 3'd5);
        send(14'sd16);
        send(14'sd24);
        wait_cycles(4);
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL tx_count got %0d expected 3", got_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            g = got_q[i];
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL tx_dout[%0d] got %0d expected %0d", i, g, e);
            end
        end
        end_line();
        clear_capture();
        start = 1'b1;
        send(14'sd0);
        send(14'sd8);
        wait_cycles(4);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 32'sd64) begin
            errors++;
            $display("FAIL lut_protect count %0d first %0d expected 1 64",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'sd0);
        end
        end_line();
    endtask

    task automatic test_start_drop();
        lut_write(2'd0, 3'd3);
        lut_write(2'd1, 3'd1);
        apo_din = 16'sd8;
        clear_capture();
        start = 1'b1;
        send(14'sd0);
        send(14'sd80);
        start = 1'b0;
        tick();
        checks++;
        if (dout !== 32'sd0 || dout_valid !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL drop_idle dout %0d valid %b state %0d expected 0 0 0", dout, dout_valid, dbg_state);
        end
        wait_cycles(4);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL drop_no_output got %0d outputs expected 0", got_q.size());
        end
        start = 1'b1;
        send(14'sd40);
        send(14'sd48);
        wait_cycles(4);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 32'sd360) begin
            errors++;
            $display("FAIL drop_restart count %0d first %0d expected 1 360",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'sd0);
        end
        end_line();
    endtask

    initial begin
        rst_n = 1'b1;
        tx_en = 1'b0;
        start = 1'b0;
        fine_din = '0;
        fine_din_valid = 1'b0;
        lut_addr = '0;
        lut_we = 1'b0;
        lut_din = '0;
        apo_din = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back_wrap();
        test_tx_gating();
        test_start_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
